// File: rtl/keycode_note_decoder_if.sv
// Note-event bus between the keycode decoder and a downstream voice.
// ev_valid/ev_ready: an event transfers on a cycle where both are high; while ev_valid is high and ev_ready low, ev_on/ev_note hold steady.
interface keycode_note_decoder_if;
    logic [7:0] keycode;
    logic       ev_valid;
    logic       ev_ready;
    logic       ev_on;
    logic [6:0] ev_note;
    logic       gate;
    logic [2:0] octave;
    logic       busy;
    logic [1:0] dbg_state;

    modport master (
        output keycode, ev_ready,
        input  ev_valid, ev_on, ev_note, gate, octave, busy, dbg_state
    );

    modport slave (
        input  keycode, ev_ready,
        output ev_valid, ev_on, ev_note, gate, octave, busy, dbg_state
    );
endinterface

// File: rtl/keycode_note_decoder.sv
// Debounces a HID keycode and turns settled key changes into note-off/note-on events,
// with octave-shift keys and a gate that tracks the sounding note.
module keycode_note_decoder #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned OCT_RESET     = 4
) (
    input logic clk,
    input logic reset,
    keycode_note_decoder_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EMIT_OFF = 2'd1,
        EMIT_ON  = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE   = 8'(SETTLE_CYCLES);
    localparam logic [2:0] OCT_INIT = 3'(OCT_RESET);

    state_t     state_q, state_d;
    logic [7:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] acc_q, acc_d;
    logic [2:0] oct_q, oct_d;
    logic       gate_q, gate_d;
    logic       on_pend_q, on_pend_d;
    logic [6:0] note_q, note_d;
    logic [6:0] active_q, active_d;

    logic       accept;
    logic       hs;
    logic       is_note;
    logic [3:0] semi;
    logic [2:0] oct_new;
    logic [6:0] note_calc;

    always_comb begin
        is_note = 1'b1;
        semi    = 4'd0;
        case (cand_q)
            8'h04: semi = 4'd0;
            8'h1A: semi = 4'd1;
            8'h16: semi = 4'd2;
            8'h08: semi = 4'd3;
            8'h07: semi = 4'd4;
            8'h09: semi = 4'd5;
            8'h17: semi = 4'd6;
            8'h0A: semi = 4'd7;
            8'h1C: semi = 4'd8;
            8'h0B: semi = 4'd9;
            8'h18: semi = 4'd10;
            8'h0D: semi = 4'd11;
            8'h0E: semi = 4'd12;
            default: is_note = 1'b0;
        endcase
    end

    // The note of an accepted key uses the octave as it stands after this same accept.
    always_comb begin
        oct_new = oct_q;
        if (cand_q == 8'h1D && oct_q != 3'd0) begin
            oct_new = oct_q - 3'd1;
        end else if (cand_q == 8'h1B && oct_q != 3'd7) begin
            oct_new = oct_q + 3'd1;
        end
        note_calc = 7'd12 * ({4'd0, oct_new} + 7'd1) + {3'd0, semi};
    end

    assign accept = (state_q == IDLE) && (cnt_q == SETTLE) && (cand_q != acc_q);
    assign hs     = bus.ev_valid && bus.ev_ready;

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        oct_d     = oct_q;
        gate_d    = gate_q;
        on_pend_d = on_pend_q;
        note_d    = note_q;
        active_d  = active_q;

        if (bus.keycode != cand_q) begin
            cand_d = bus.keycode;
            cnt_d  = 8'd0;
        end else if (cnt_q != SETTLE) begin
            cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    acc_d     = cand_q;
                    oct_d     = oct_new;
                    note_d    = note_calc;
                    on_pend_d = is_note;
                    if (gate_q) begin
                        state_d = EMIT_OFF;
                    end else if (is_note) begin
                        state_d = EMIT_ON;
                    end
                end
            end
            EMIT_OFF: begin
                if (hs) begin
                    gate_d  = 1'b0;
                    state_d = on_pend_q ? EMIT_ON : IDLE;
                end
            end
            EMIT_ON: begin
                if (hs) begin
                    gate_d   = 1'b1;
                    active_d = note_q;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cand_q    <= 8'd0;
            cnt_q     <= 8'd0;
            acc_q     <= 8'd0;
            oct_q     <= OCT_INIT;
            gate_q    <= 1'b0;
            on_pend_q <= 1'b0;
            note_q    <= 7'd0;
            active_q  <= 7'd0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            oct_q     <= oct_d;
            gate_q    <= gate_d;
            on_pend_q <= on_pend_d;
            note_q    <= note_d;
            active_q  <= active_d;
        end
    end

    // A note-off always reports the latched sounding note, not a recomputed one.
    assign bus.ev_valid  = (state_q != IDLE);
    assign bus.ev_on     = (state_q == EMIT_ON);
    assign bus.ev_note   = (state_q == EMIT_OFF) ? active_q :
                           (state_q == EMIT_ON)  ? note_q   : 7'd0;
    assign bus.gate      = gate_q;
    assign bus.octave    = oct_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.dbg_state = state_q;
endmodule
